phase_counter: RTL

Upstream phase source for the function-generator waveform stages (square, triangle, sawtooth). It produces the 8-bit phase value count_clk that those stages decode. A programmable prescaler sets the output frequency: f_out = f_clk / ((div_active+1)*256). Frequency changes are staged and applied only at a phase wrap, so downstream waveforms stay glitch-free.

---
 rtl/phase_counter_if.sv | 30 +++
 rtl/phase_counter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/phase_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : phase_counter_if
// Description : Control and phase-output bundle of the phase counter.
// Revision    : 1.0 - initial release
// ============================================================================
interface phase_counter_if #(
  parameter int PHASE_W = 8,
  parameter int DIV_W   = 16
);
  logic               en;
  logic               sync;
  logic               freq_load;
  logic [DIV_W-1:0]   freq_div;
  logic [PHASE_W-1:0] count_clk;
  logic               tick;
  logic               wrap;
  logic               pending;

  modport master (
    output en, sync, freq_load, freq_div,
    input  count_clk, tick, wrap, pending
  );

  modport slave (
    input  en, sync, freq_load, freq_div,
    output count_clk, tick, wrap, pending
  );
endinterface
`default_nettype wire

// File: rtl/phase_counter.sv
`default_nettype none
// ============================================================================
// Module      : phase_counter
// Description : Prescaled 8-bit phase source; divide changes land on a wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_counter #(
  parameter int          PHASE_W     = 8,
  parameter int          DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 0
) (
  input  wire logic        clk,
  input  wire logic        rst,
  phase_counter_if.slave   bus
);
  localparam logic [DIV_W-1:0] c_div_rst = DIV_W'(DEFAULT_DIV);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    RUN_PEND = 2'd2
  } state_t;

  state_t             r_state,       w_state_nxt;
  logic [PHASE_W-1:0] r_count,       w_count_nxt;
  logic [DIV_W-1:0]   r_pre_cnt,     w_pre_cnt_nxt;
  logic [DIV_W-1:0]   r_div_active,  w_div_active_nxt;
  logic [DIV_W-1:0]   r_div_pending, w_div_pending_nxt;
  logic               r_tick,        w_tick_nxt;
  logic               r_wrap,        w_wrap_nxt;
  logic               r_pending,     w_pending_nxt;
  logic               w_terminal;
  logic               w_at_wrap;

  assign w_terminal = (r_pre_cnt == r_div_active);
  assign w_at_wrap  = w_terminal && (r_count == {PHASE_W{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_count       <= '0;
      r_pre_cnt     <= '0;
      r_div_active  <= c_div_rst;
      r_div_pending <= c_div_rst;
      r_tick        <= 1'b0;
      r_wrap        <= 1'b0;
      r_pending     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_count       <= w_count_nxt;
      r_pre_cnt     <= w_pre_cnt_nxt;
      r_div_active  <= w_div_active_nxt;
      r_div_pending <= w_div_pending_nxt;
      r_tick        <= w_tick_nxt;
      r_wrap        <= w_wrap_nxt;
      r_pending     <= w_pending_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_count_nxt       = r_count;
    w_pre_cnt_nxt     = r_pre_cnt;
    w_div_active_nxt  = r_div_active;
    w_div_pending_nxt = r_div_pending;
    w_tick_nxt        = 1'b0;
    w_wrap_nxt        = 1'b0;
    w_pending_nxt     = r_pending;

    if (bus.sync) begin
      w_count_nxt   = '0;
      w_pre_cnt_nxt = '0;
      w_pending_nxt = 1'b0;
      w_state_nxt   = bus.en ? RUN : IDLE;
      if (bus.freq_load)
        w_div_active_nxt = bus.freq_div;
      else if (r_pending)
        w_div_active_nxt = r_div_pending;
      w_div_pending_nxt = w_div_active_nxt;
    end else if (!bus.en) begin
      // Stopping flushes any staged value; a coincident load overrides it.
      w_pre_cnt_nxt = '0;
      w_pending_nxt = 1'b0;
      w_state_nxt   = IDLE;
      if (bus.freq_load)
        w_div_active_nxt = bus.freq_div;
      else if (r_pending)
        w_div_active_nxt = r_div_pending;
      w_div_pending_nxt = w_div_active_nxt;
    end else begin
      if (w_terminal) begin
        w_pre_cnt_nxt = '0;
        w_count_nxt   = r_count + PHASE_W'(1);
        w_tick_nxt    = 1'b1;
        w_wrap_nxt    = w_at_wrap;
      end else begin
        w_pre_cnt_nxt = r_pre_cnt + DIV_W'(1);
      end

      case (r_state)
        IDLE: begin
          w_state_nxt = RUN;
          if (bus.freq_load) begin
            w_div_active_nxt  = bus.freq_div;
            w_div_pending_nxt = bus.freq_div;
          end
        end
        RUN: begin
          if (bus.freq_load) begin
            w_div_pending_nxt = bus.freq_div;
            w_pending_nxt     = 1'b1;
            w_state_nxt       = RUN_PEND;
          end
        end
        RUN_PEND: begin
          if (w_at_wrap) begin
            // Old staged value lands now; a same-cycle load waits for the next wrap.
            w_div_active_nxt = r_div_pending;
            if (bus.freq_load) begin
              w_div_pending_nxt = bus.freq_div;
            end else begin
              w_pending_nxt = 1'b0;
              w_state_nxt   = RUN;
            end
          end else if (bus.freq_load) begin
            w_div_pending_nxt = bus.freq_div;
          end
        end
        default: begin
          w_state_nxt   = IDLE;
          w_pending_nxt = 1'b0;
        end
      endcase
    end
  end

  assign bus.count_clk = r_count;
  assign bus.tick      = r_tick;
  assign bus.wrap      = r_wrap;
  assign bus.pending   = r_pending;
endmodule
`default_nettype wire
